// File: rtl/sfx_audio_arbiter.sv
// sfx_audio_arbiter: shares the note_gen datapath between background music and prioritized one-shot sound effects
module sfx_audio_arbiter #(
    parameter int NUM_SFX  = 4,
    parameter int TICK_DIV = 1000000,
    parameter int LEN_W    = 8,
    localparam int ID_W    = (NUM_SFX > 1) ? $clog2(NUM_SFX) : 1,
    localparam int CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     music_en,
    input  logic [21:0]              music_div_left,
    input  logic [21:0]              music_div_right,
    input  logic [2:0]               music_volume,
    input  logic [NUM_SFX-1:0]       sfx_req,
    input  logic [22*NUM_SFX-1:0]    sfx_div,
    input  logic [LEN_W*NUM_SFX-1:0] sfx_len,
    input  logic [2:0]               sfx_volume,
    output logic [21:0]              note_div_left,
    output logic [21:0]              note_div_right,
    output logic [2:0]               volume,
    output logic                     sfx_active,
    output logic [ID_W-1:0]          sfx_active_id,
    output logic [NUM_SFX-1:0]       sfx_ack,
    output logic [NUM_SFX-1:0]       sfx_done
);
    typedef enum logic {MUSIC, SFX} state_t;
    state_t             state_q, state_d;
    logic [NUM_SFX-1:0] pending_q, pending_d;
    logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic [ID_W-1:0]    active_id_q, active_id_d;
    logic [21:0]        div_q, div_d;
    logic [21:0]        left_q, left_d, right_q, right_d;
    logic [2:0]         volume_q, volume_d;
    logic               active_q, active_d;
    logic [NUM_SFX-1:0] ack_q, ack_d, done_q, done_d;
    logic [ID_W-1:0]    win_id;
    logic [LEN_W-1:0]   win_len;
    logic [NUM_SFX-1:0] win_mask;
    logic               any, tick, preempt, grant, finish, sfx_on;
    always_comb begin
        win_id = '0;
        for (int i = NUM_SFX - 1; i >= 0; i--)
            if (pending_q[i]) win_id = ID_W'(i);
        any      = |pending_q;
        win_mask = NUM_SFX'(1) << win_id;
        win_len  = sfx_len[int'(win_id)*LEN_W +: LEN_W];
        tick     = tick_cnt_q == CNT_W'(TICK_DIV - 1);
        preempt  = state_q == SFX && any && win_id < active_id_q;
        grant    = (state_q == MUSIC && any) || preempt;
        // preemption outranks a completion landing on the same edge, so no done pulse then
        finish   = state_q == SFX && !preempt && tick && remaining_q == LEN_W'(1);
        state_d     = grant ? SFX : finish ? MUSIC : state_q;
        active_id_d = grant ? win_id : active_id_q;
        div_d       = grant ? sfx_div[int'(win_id)*22 +: 22] : div_q;
        tick_cnt_d  = (grant || state_q == MUSIC || tick) ? '0 : tick_cnt_q + CNT_W'(1);
        remaining_d = grant ? (win_len == '0 ? LEN_W'(1) : win_len)
                    : (state_q == SFX && tick) ? remaining_q - LEN_W'(1) : remaining_q;
        pending_d   = (pending_q & ~(grant ? win_mask : '0)) | sfx_req;
        ack_d       = grant ? win_mask : '0;
        done_d      = finish ? NUM_SFX'(1) << active_id_q : '0;
        sfx_on      = state_d == SFX;
        left_d      = sfx_on ? div_d : music_en ? music_div_left : 22'd1;
        right_d     = sfx_on ? div_d : music_en ? music_div_right : 22'd1;
        volume_d    = sfx_on ? sfx_volume : music_en ? music_volume : 3'd0;
        active_d    = sfx_on;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= MUSIC;
            pending_q   <= '0;
            tick_cnt_q  <= '0;
            remaining_q <= '0;
            active_id_q <= '0;
            div_q       <= 22'd1;
            left_q      <= 22'd1;
            right_q     <= 22'd1;
            volume_q    <= 3'd0;
            active_q    <= 1'b0;
            ack_q       <= '0;
            done_q      <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            tick_cnt_q  <= tick_cnt_d;
            remaining_q <= remaining_d;
            active_id_q <= active_id_d;
            div_q       <= div_d;
            left_q      <= left_d;
            right_q     <= right_d;
            volume_q    <= volume_d;
            active_q    <= active_d;
            ack_q       <= ack_d;
            done_q      <= done_d;
        end
    end
    assign note_div_left  = left_q;
    assign note_div_right = right_q;
    assign volume         = volume_q;
    assign sfx_active     = active_q;
    assign sfx_active_id  = active_id_q;
    assign sfx_ack        = ack_q;
    assign sfx_done       = done_q;
endmodule

// File: tb/tb_sfx_audio_arbiter.sv
// tb_sfx_audio_arbiter: directed plus random stimulus against a cycle-count reference model
module tb_sfx_audio_arbiter;
    localparam int N  = 4;
    localparam int TD = 4;
    localparam int LW = 8;
    logic            clk = 0, rst = 1, music_en = 0;
    logic [21:0]     mdl = 0, mdr = 0;
    logic [2:0]      mv = 0, svol = 0;
    logic [N-1:0]    req = 0;
    logic [22*N-1:0] sdiv = 0;
    logic [LW*N-1:0] slen = 0;
    logic [21:0]     note_div_left, note_div_right;
    logic [2:0]      volume;
    logic            sfx_active;
    logic [1:0]      sfx_active_id;
    logic [N-1:0]    sfx_ack, sfx_done;
    int vectors = 0, miscompares = 0;
    logic         m_sfx;
    int           m_id, m_left;
    logic [N-1:0] m_pend;
    logic [21:0]  m_div, e_l, e_r;
    logic [2:0]   e_v;
    logic [N-1:0] e_ack, e_done;
    sfx_audio_arbiter #(.NUM_SFX(N), .TICK_DIV(TD), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst), .music_en(music_en),
        .music_div_left(mdl), .music_div_right(mdr), .music_volume(mv),
        .sfx_req(req), .sfx_div(sdiv), .sfx_len(slen), .sfx_volume(svol),
        .note_div_left(note_div_left), .note_div_right(note_div_right), .volume(volume),
        .sfx_active(sfx_active), .sfx_active_id(sfx_active_id),
        .sfx_ack(sfx_ack), .sfx_done(sfx_done)
    );
    always #5 clk = ~clk;
    // Model tracks whole cycles left in the effect rather than tick/remaining counters
    task automatic model_step();
        int w, len;
        e_ack = '0;
        e_done = '0;
        if (rst) begin
            m_sfx = 0; m_id = 0; m_left = 0; m_pend = '0; m_div = 22'd1;
            e_l = 22'd1; e_r = 22'd1; e_v = 3'd0;
            return;
        end
        w = -1;
        for (int i = N - 1; i >= 0; i--) if (m_pend[i]) w = i;
        if (w >= 0 && (!m_sfx || w < m_id)) begin
            len = int'(slen[LW*w +: LW]);
            if (len == 0) len = 1;
            m_sfx = 1; m_id = w; m_div = sdiv[22*w +: 22]; m_left = len * TD;
            m_pend[w] = 1'b0;
            e_ack[w] = 1'b1;
        end else if (m_sfx) begin
            m_left--;
            if (m_left == 0) begin
                m_sfx = 0;
                e_done[m_id] = 1'b1;
            end
        end
        m_pend = m_pend | req;
        e_l = m_sfx ? m_div : music_en ? mdl : 22'd1;
        e_r = m_sfx ? m_div : music_en ? mdr : 22'd1;
        e_v = m_sfx ? svol : music_en ? mv : 3'd0;
    endtask
    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, got, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("note_div_left", 32'(note_div_left), 32'(e_l));
        chk("note_div_right", 32'(note_div_right), 32'(e_r));
        chk("volume", 32'(volume), 32'(e_v));
        chk("sfx_active", 32'(sfx_active), 32'(m_sfx));
        chk("sfx_active_id", 32'(sfx_active_id), 32'(m_id));
        chk("sfx_ack", 32'(sfx_ack), 32'(e_ack));
        chk("sfx_done", 32'(sfx_done), 32'(e_done));
        req = '0;
    endtask
    task automatic set_fx(int i, int div, int len);
        sdiv[22*i +: 22] = 22'(div);
        slen[LW*i +: LW] = LW'(len);
    endtask
    initial begin
        for (int i = 0; i < N; i++) set_fx(i, 1000 + i, 1);
        rst = 1;
        repeat (3) cyc();
        rst = 0; music_en = 1; mdl = 22'd191571; mdr = 22'd151686; mv = 3'd3;
        repeat (2) cyc();
        set_fx(2, 50000, 3); svol = 3'd5; req = 4'b0100;
        repeat (18) cyc();
        set_fx(3, 33333, 10); set_fx(0, 7777, 2); req = 4'b1000;
        repeat (6) cyc();
        req = 4'b0001;
        repeat (16) cyc();
        set_fx(1, 1234, 2); req = 4'b0010;
        repeat (4) cyc();
        req = 4'b1000;
        repeat (60) cyc();
        set_fx(1, 4321, 0); req = 4'b1010;
        repeat (60) cyc();
        music_en = 0;
        repeat (2) cyc();
        music_en = 1; req = 4'b0001;
        repeat (4) cyc();
        req = 4'b0100;
        cyc();
        rst = 1;
        cyc();
        rst = 0;
        repeat (20) cyc();
        repeat (4000) begin
            req = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
            if ($urandom_range(0, 15) == 0) set_fx($urandom_range(0, N - 1), $urandom, $urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) begin
                music_en = 1'($urandom); mdl = 22'($urandom); mdr = 22'($urandom); mv = 3'($urandom);
            end
            if ($urandom_range(0, 7) == 0) svol = 3'($urandom);
            rst = $urandom_range(0, 299) == 0;
            cyc();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
